// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer for a word-wide data memory
// without byte enables. Sub-word stores are done as read-modify-write;
// sub-word loads are extracted from the read word and sign/zero extended.
module load_store_unit #(
    parameter int register_count = 32,
    parameter int data_length    = 32   // lane logic assumes 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_store,
    input  logic [2:0]                        funct3,
    input  logic [data_length-1:0]            req_addr,
    input  logic [data_length-1:0]            req_wdata,
    output logic                              resp_valid,
    output logic [data_length-1:0]            resp_rdata,
    output logic                              fault,
    output logic [$clog2(register_count)-1:0] rw_addr_mem,
    output logic [data_length-1:0]            w_data_mem,
    output logic                              r_ctrl_mem,
    output logic                              w_ctrl_mem,
    input  logic [data_length-1:0]            r_data_mem
);
    localparam int AW        = $clog2(register_count);
    localparam int NUM_LANES = data_length / 8;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    // Only what the READ/WRITE phases still need after accept is kept;
    // the word address already lives in rw_addr_mem.
    typedef struct packed {
        logic        store;
        logic [2:0]  funct3;
        logic [1:0]  lane;
        logic [15:0] wdata;
    } req_t;

    state_t                 state;
    req_t                   cur;
    logic [AW-1:0]          req_waddr;
    logic                   bad_code;
    logic                   misaligned;
    logic                   req_fault;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic [data_length-1:0] load_ext;
    logic [data_length-1:0] merged;
    logic                   unused_addr_hi;

    // Address bits above the memory size are dropped, so accesses wrap.
    assign req_waddr      = req_addr[AW+1:2];
    assign unused_addr_hi = ^req_addr[data_length-1:AW+2];

    // Reserved codes, unsigned stores, and misaligned half/word accesses.
    assign bad_code   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                        (req_store && funct3[2]);
    assign misaligned = ((funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign req_fault  = bad_code || misaligned;

    assign ld_byte = r_data_mem[{cur.lane, 3'b000} +: 8];
    assign ld_half = r_data_mem[{cur.lane[1], 4'b0000} +: 16];

    // Per byte lane: take store data where the SB/SH targets this lane,
    // otherwise keep the word just read from memory.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic       sel;
        logic [7:0] src;
        assign sel = (cur.funct3[1:0] == 2'b00) ? (cur.lane == 2'(i))
                                                : (cur.lane[1] == ((i / 2) != 0));
        assign src = (cur.funct3[1:0] == 2'b00) ? cur.wdata[7:0]
                                                : cur.wdata[8*(i%2) +: 8];
        assign merged[8*i +: 8] = sel ? src : r_data_mem[8*i +: 8];
    end

    // Width selection and sign/zero extension of the load result.
    always_comb begin
        load_ext = r_data_mem;
        case (cur.funct3)
            3'b000:  load_ext = {{(data_length-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {{(data_length-8){1'b0}}, ld_byte};
            3'b001:  load_ext = {{(data_length-16){ld_half[15]}}, ld_half};
            3'b101:  load_ext = {{(data_length-16){1'b0}}, ld_half};
            default: load_ext = r_data_mem;
        endcase
    end

    // Request sequencer; every memory and response output is registered so
    // reset drops the control lines immediately, cancelling a pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur         <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            fault       <= 1'b0;
            resp_rdata  <= '0;
            r_ctrl_mem  <= 1'b0;
            w_ctrl_mem  <= 1'b0;
            w_data_mem  <= '0;
            rw_addr_mem <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur       <= '{store: req_store, funct3: funct3,
                                       lane: req_addr[1:0], wdata: req_wdata[15:0]};
                        req_ready <= 1'b0;
                        if (req_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            fault      <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_store && (funct3[1:0] == 2'b10)) begin
                            state       <= WRITE;
                            w_ctrl_mem  <= 1'b1;
                            rw_addr_mem <= req_waddr;
                            w_data_mem  <= req_wdata;
                        end else begin
                            state       <= READ;
                            r_ctrl_mem  <= 1'b1;
                            rw_addr_mem <= req_waddr;
                        end
                    end
                end
                READ: begin
                    r_ctrl_mem <= 1'b0;
                    if (cur.store) begin
                        state      <= WRITE;
                        w_ctrl_mem <= 1'b1;
                        w_data_mem <= merged;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        fault      <= 1'b0;
                        resp_rdata <= load_ext;
                    end
                end
                WRITE: begin
                    state      <= RESP;
                    w_ctrl_mem <= 1'b0;
                    resp_valid <= 1'b1;
                    fault      <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    fault      <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side initiator for the data memory. Turns RV32I load/store requests from the execute stage into word-wide memory accesses.
- Handles sub-word accesses with byte-lane extraction and sign/zero extension on loads.
- SB/SH use read-modify-write, because the memory port has no byte enables.
- Sits between execute/writeback and the data memory, driving its address, write data and read/write control lines.

Parameters:
- register_count, 32, number of words in data memory; word address width is $clog2(register_count).
- data_length, 32, word width; must be 32 (RV32I lane logic).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle, request accepted when req_valid && req_ready
- req_store  input  1  1 = store, 0 = load
- funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  data_length  byte address
- req_wdata  input  data_length  store data (low lanes used for SB/SH)
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  data_length  extended load result; 0 for stores and faults
- fault  output  1  valid with resp_valid; misaligned or illegal funct3
- rw_addr_mem  output  $clog2(register_count)  word address to memory
- w_data_mem  output  data_length  write word to memory
- r_ctrl_mem  output  1  memory read enable
- w_ctrl_mem  output  1  memory write enable; memory writes on the rising clk edge
- r_data_mem  input  data_length  full-width combinational read word from memory

Behaviour:
- Interface decision: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; req_ready=1; resp_valid, fault, r_ctrl_mem, w_ctrl_mem = 0; resp_rdata, w_data_mem, rw_addr_mem = 0. All captured request registers are cleared.
- Word address = req_addr[$clog2(register_count)+1:2]. Upper bits are ignored, so addresses wrap modulo memory size. Lane = req_addr[1:0].
- Fault conditions:
  - funct3 in {011,110,111}.
  - Store with funct3 100 or 101.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On accept, capture addr, funct3, req_store and wdata, then branch:
  - fault -> RESP with fault=1
  - SW -> WRITE
  - otherwise -> READ
- READ: r_ctrl_mem=1, rw_addr_mem=word address. The unit samples r_data_mem at the exit edge.
  - Load: the extended result is registered into resp_rdata, then -> RESP.
  - SB/SH: the merged word is registered, then -> WRITE.
- WRITE: w_ctrl_mem=1 for exactly one cycle, with w_data_mem = merged word (SW: req_wdata), then -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. req_ready=0 in every state except IDLE, so back-to-back requests have one idle cycle between them.
- r_ctrl_mem and w_ctrl_mem are never high together, and are both 0 outside READ and WRITE.
- Latency (cycles after the accept cycle in which resp_valid is high):
  - fault: 1
  - SW: 2
  - load: 2
  - SB/SH: 3
- Load extraction:
  - LB/LBU: byte = word[8*lane +: 8].
  - LH/LHU: half = word[16*lane[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store merge: SB replaces byte lane with wdata[7:0]; SH replaces the half lane with wdata[15:0]; other lanes keep the read word.
- resp_rdata holds its value until the next response. It is 0 for stores and faults.
- Reset mid-operation: state returns to IDLE immediately, and the control lines drop asynchronously. A write whose WRITE cycle is cut by reset before the clock edge must not occur. No resp_valid is generated for the aborted request.

Test Plan:
- Reset: assert rst mid-run -> all outputs at their reset values within the same cycle; req_ready=1 after release.
- SW 0xDEADBEEF @0x08, then LW @0x08:
  - SW -> exactly one w_ctrl_mem cycle with rw_addr_mem=2 and resp_valid 2 cycles after accept.
  - LW -> resp_rdata=0xDEADBEEF.
- Word @0x08 preset to 0x11223344; SB 0x000000AA @0x09:
  - memory word becomes 0x1122AA44.
  - LB @0x09 -> 0xFFFFFFAA; LBU @0x09 -> 0x000000AA; LB @0x0B -> 0x00000011.
- Word @0x0C preset to 0xDEADBEEF; SH 0x00008001 @0x0E:
  - memory word becomes 0x8001BEEF.
  - LH @0x0E -> 0xFFFF8001; LHU @0x0E -> 0x00008001.
- Faults: LW @0x06, SH @0x03, load funct3=011, store funct3=100 -> each gives fault=1 with resp_valid 1 cycle after accept, no r_ctrl_mem/w_ctrl_mem activity, resp_rdata=0.
- Wrap and abort:
  - LW @0x80 with register_count=32 -> reads word 0.
  - SB with rst asserted during WRITE before the edge -> memory unchanged and no resp_valid.
